// File: rtl/rm14_pkg.sv
// Shared RM(1,4) constants: systematic parity-check columns, syndrome helper,
// candidate count per search depth, controller state encoding and result record.
package rm14_pkg;

   localparam int N = 16;
   localparam int K = 5;
   localparam int R = 11;

   // Column b of H = [P^T | I11]. Bits 15..11 carry the message and map to the
   // affine points 0, e1, e2, e3, e4. Parity bits 10..0 map to the remaining points.
   localparam logic [R-1:0] H_COL [0:N-1] = '{
      11'b00000000001, 11'b00000000010, 11'b00000000100, 11'b00000001000,
      11'b00000010000, 11'b00000100000, 11'b00001000000, 11'b00010000000,
      11'b00100000000, 11'b01000000000, 11'b10000000000,
      11'b11111110000, 11'b11110001110, 11'b11001101101,
      11'b10101011011, 11'b10010110111
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef struct packed {
      logic [K-1:0] msg;
      logic [N-1:0] codeword;
      logic [1:0]   err_weight;
      logic         uncorrectable;
   } result_t;

   function automatic logic [R-1:0] syndrome(input logic [N-1:0] w);
      logic [R-1:0] s;
      s = '0;
      for (int b = 0; b < N; b++)
         if (w[b]) s ^= H_COL[b];
      return s;
   endfunction

   function automatic int num_cand(input int max_weight);
      case (max_weight)
         1:       return 17;
         2:       return 137;
         default: return 697;
      endcase
   endfunction

endpackage

// File: rtl/rm14_search_ctrl_if.sv
// Received-word input handshake, corrected-result output handshake and statistics.
interface rm14_search_ctrl_if;
   import rm14_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_word;
   logic         out_valid;
   logic         out_ready;
   logic [K-1:0] out_msg;
   logic [N-1:0] out_codeword;
   logic [1:0]   out_err_weight;
   logic         out_uncorrectable;
   logic [15:0]  corr_count;
   logic [15:0]  fail_count;

   modport master (
      output in_valid, in_word, out_ready,
      input  in_ready, out_valid, out_msg, out_codeword, out_err_weight,
             out_uncorrectable, corr_count, fail_count
   );

   modport slave (
      input  in_valid, in_word, out_ready,
      output in_ready, out_valid, out_msg, out_codeword, out_err_weight,
             out_uncorrectable, corr_count, fail_count
   );

endinterface

// File: rtl/rm14_pattern_gen.sv
// Enumerates error patterns of weight 0..MAX_WEIGHT, one per advance, in
// lexicographic (i<j<k) order within each weight.
module rm14_pattern_gen
   import rm14_pkg::*;
#(
   parameter int MAX_WEIGHT = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         advance,
   output logic         last,
   output logic [N-1:0] pattern,
   output logic [1:0]   weight
);

   localparam logic [9:0] LAST_IDX = 10'(num_cand(MAX_WEIGHT) - 1);

   logic [9:0] idx;
   logic [3:0] i, j, k;
   logic [1:0] w;

   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         idx <= '0;
         w   <= 2'd0;
         i   <= 4'd0;
         j   <= 4'd0;
         k   <= 4'd0;
      end else if (advance) begin
         idx <= idx + 10'd1;
         case (w)
            2'd0: begin
               w <= 2'd1;
               i <= 4'd0;
            end
            2'd1: begin
               if (i != 4'd15) i <= i + 4'd1;
               else begin
                  w <= 2'd2; i <= 4'd0; j <= 4'd1;
               end
            end
            2'd2: begin
               if (j != 4'd15) j <= j + 4'd1;
               else if (i != 4'd14) begin
                  i <= i + 4'd1; j <= i + 4'd2;
               end else begin
                  w <= 2'd3; i <= 4'd0; j <= 4'd1; k <= 4'd2;
               end
            end
            default: begin
               // the final triple (13,14,15) is never advanced past
               if (k != 4'd15) k <= k + 4'd1;
               else if (j != 4'd14) begin
                  j <= j + 4'd1; k <= j + 4'd2;
               end else if (i != 4'd13) begin
                  i <= i + 4'd1; j <= i + 4'd2; k <= i + 4'd3;
               end
            end
         endcase
      end
   end

   always_comb begin
      pattern = '0;
      if (w >= 2'd1) pattern[i] = 1'b1;
      if (w >= 2'd2) pattern[j] = 1'b1;
      if (w == 2'd3) pattern[k] = 1'b1;
   end

   assign last   = (idx == LAST_IDX);
   assign weight = w;

endmodule

// File: rtl/rm14_search_ctrl.sv
// Sequential RM(1,4) syndrome search: one candidate error pattern per clock,
// first match wins, result held until the consumer takes it.
module rm14_search_ctrl
   import rm14_pkg::*;
#(
   parameter int MAX_WEIGHT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   rm14_search_ctrl_if.slave   bus
);

   localparam logic [1:0] IDLE   = ST_IDLE;
   localparam logic [1:0] SEARCH = ST_SEARCH;
   localparam logic [1:0] DONE   = ST_DONE;

   logic [1:0]   state;
   logic [N-1:0] word;
   logic [R-1:0] syn;
   result_t      res;
   logic [15:0]  corr_count, fail_count;

   logic         accept, match, last, advance;
   logic [N-1:0] pattern;
   logic [1:0]   cand_weight;

   assign accept  = (state == IDLE) && bus.in_valid;
   assign match   = (syndrome(pattern) == syn);
   assign advance = (state == SEARCH) && !match && !last;

   rm14_pattern_gen #(.MAX_WEIGHT(MAX_WEIGHT)) u_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept),
      .advance (advance),
      .last    (last),
      .pattern (pattern),
      .weight  (cand_weight)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         word       <= '0;
         syn        <= '0;
         res        <= '0;
         corr_count <= '0;
         fail_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  word  <= bus.in_word;
                  syn   <= syndrome(bus.in_word);
                  state <= SEARCH;
               end
            end
            SEARCH: begin
               if (match) begin
                  res.codeword      <= word ^ pattern;
                  res.msg           <= word[15:11] ^ pattern[15:11];
                  res.err_weight    <= cand_weight;
                  res.uncorrectable <= 1'b0;
                  state             <= DONE;
               end else if (last) begin
                  res.codeword      <= word;
                  res.msg           <= word[15:11];
                  res.err_weight    <= 2'd0;
                  res.uncorrectable <= 1'b1;
                  state             <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  if (res.uncorrectable) begin
                     if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
                  end else if (res.err_weight != 2'd0) begin
                     if (corr_count != 16'hFFFF) corr_count <= corr_count + 16'd1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready          = (state == IDLE) && rst_n;
   assign bus.out_valid         = (state == DONE);
   assign bus.out_msg           = res.msg;
   assign bus.out_codeword      = res.codeword;
   assign bus.out_err_weight    = res.err_weight;
   assign bus.out_uncorrectable = res.uncorrectable;
   assign bus.corr_count        = corr_count;
   assign bus.fail_count        = fail_count;

endmodule

// File: tb/tb_rm14_search_ctrl.sv
// Directed bench for rm14_search_ctrl: latency, corrected outputs, stall/queue
// behaviour, statistics and mid-search reset.
module tb_rm14_search_ctrl;
   import rm14_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   rm14_search_ctrl_if bus();

   rm14_search_ctrl #(.MAX_WEIGHT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Accept one word (edge E0) and return n where out_valid first shows after E0+n, -1 on timeout.
   task automatic send_and_wait(input logic [15:0] w, output int lat);
      @(negedge clk);
      bus.in_word  = w;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_word  = 16'($urandom);
      lat = -1;
      for (int n = 1; n <= 800; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic take_result();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_word = 16'h0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.out_codeword !== 16'h0000) begin failures++; $display("FAIL reset_cw got=%h exp=0000", bus.out_codeword); end
      checks++; if (bus.out_msg !== 5'd0) begin failures++; $display("FAIL reset_msg got=%h exp=00", bus.out_msg); end
      checks++; if (bus.out_err_weight !== 2'd0) begin failures++; $display("FAIL reset_weight got=%0d exp=0", bus.out_err_weight); end
      checks++; if (bus.out_uncorrectable !== 1'b0) begin failures++; $display("FAIL reset_unc got=%b exp=0", bus.out_uncorrectable); end
      checks++; if (bus.corr_count !== 16'd0) begin failures++; $display("FAIL reset_corr got=%0d exp=0", bus.corr_count); end
      checks++; if (bus.fail_count !== 16'd0) begin failures++; $display("FAIL reset_fail got=%0d exp=0", bus.fail_count); end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_zero_word();
      int lat;
      send_and_wait(16'h0000, lat);
      checks++; if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
      checks++; if (bus.out_codeword !== 16'h0000) begin failures++; $display("FAIL zero_cw got=%h exp=0000", bus.out_codeword); end
      checks++; if (bus.out_msg !== 5'b00000) begin failures++; $display("FAIL zero_msg got=%b exp=00000", bus.out_msg); end
      checks++; if (bus.out_err_weight !== 2'd0) begin failures++; $display("FAIL zero_weight got=%0d exp=0", bus.out_err_weight); end
      checks++; if (bus.out_uncorrectable !== 1'b0) begin failures++; $display("FAIL zero_unc got=%b exp=0", bus.out_uncorrectable); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL zero_in_ready_done got=%b exp=0", bus.in_ready); end
      take_result();
      checks++; if (bus.corr_count !== 16'd0) begin failures++; $display("FAIL zero_corr got=%0d exp=0", bus.corr_count); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL zero_valid_drop got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_single_bit();
      int lat;
      send_and_wait(16'h0001, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", lat); end
      checks++; if (bus.out_codeword !== 16'h0000) begin failures++; $display("FAIL single_cw got=%h exp=0000", bus.out_codeword); end
      checks++; if (bus.out_err_weight !== 2'd1) begin failures++; $display("FAIL single_weight got=%0d exp=1", bus.out_err_weight); end
      checks++; if (bus.out_uncorrectable !== 1'b0) begin failures++; $display("FAIL single_unc got=%b exp=0", bus.out_uncorrectable); end
      take_result();
      checks++; if (bus.corr_count !== 16'd1) begin failures++; $display("FAIL single_corr got=%0d exp=1", bus.corr_count); end
      checks++; if (bus.fail_count !== 16'd0) begin failures++; $display("FAIL single_fail got=%0d exp=0", bus.fail_count); end
   endtask

   task automatic test_last_triple();
      int lat;
      send_and_wait(16'h1FFF, lat);
      checks++; if (lat !== 697) begin failures++; $display("FAIL triple_latency got=%0d exp=697", lat); end
      checks++; if (bus.out_codeword !== 16'hFFFF) begin failures++; $display("FAIL triple_cw got=%h exp=ffff", bus.out_codeword); end
      checks++; if (bus.out_msg !== 5'b11111) begin failures++; $display("FAIL triple_msg got=%b exp=11111", bus.out_msg); end
      checks++; if (bus.out_err_weight !== 2'd3) begin failures++; $display("FAIL triple_weight got=%0d exp=3", bus.out_err_weight); end
      checks++; if (bus.out_uncorrectable !== 1'b0) begin failures++; $display("FAIL triple_unc got=%b exp=0", bus.out_uncorrectable); end
      take_result();
      checks++; if (bus.corr_count !== 16'd2) begin failures++; $display("FAIL triple_corr got=%0d exp=2", bus.corr_count); end
   endtask

   task automatic test_uncorrectable();
      int lat;
      send_and_wait(16'h000F, lat);
      checks++; if (lat !== 697) begin failures++; $display("FAIL unc_latency got=%0d exp=697", lat); end
      checks++; if (bus.out_uncorrectable !== 1'b1) begin failures++; $display("FAIL unc_flag got=%b exp=1", bus.out_uncorrectable); end
      checks++; if (bus.out_codeword !== 16'h000F) begin failures++; $display("FAIL unc_cw got=%h exp=000f", bus.out_codeword); end
      checks++; if (bus.out_msg !== 5'd0) begin failures++; $display("FAIL unc_msg got=%b exp=00000", bus.out_msg); end
      checks++; if (bus.out_err_weight !== 2'd0) begin failures++; $display("FAIL unc_weight got=%0d exp=0", bus.out_err_weight); end
      take_result();
      checks++; if (bus.fail_count !== 16'd1) begin failures++; $display("FAIL unc_fail got=%0d exp=1", bus.fail_count); end
      checks++; if (bus.corr_count !== 16'd2) begin failures++; $display("FAIL unc_corr got=%0d exp=2", bus.corr_count); end
   endtask

   task automatic test_back_to_back();
      int lat;
      send_and_wait(16'h0001, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
      bus.in_word  = 16'h0000;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_stall_valid cyc=%0d got=%b exp=1", c, bus.out_valid); end
         checks++; if (bus.out_codeword !== 16'h0000) begin failures++; $display("FAIL b2b_stall_cw cyc=%0d got=%h exp=0000", c, bus.out_codeword); end
         checks++; if (bus.out_err_weight !== 2'd1) begin failures++; $display("FAIL b2b_stall_weight cyc=%0d got=%0d exp=1", c, bus.out_err_weight); end
         checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_hs got=%b exp=1", bus.in_ready); end
      checks++; if (bus.corr_count !== 16'd3) begin failures++; $display("FAIL b2b_corr got=%0d exp=3", bus.corr_count); end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_queued_accept got=%b exp=0", bus.in_ready); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%b exp=1", bus.out_valid); end
      checks++; if (bus.out_err_weight !== 2'd0) begin failures++; $display("FAIL b2b_second_weight got=%0d exp=0", bus.out_err_weight); end
      take_result();
      checks++; if (bus.corr_count !== 16'd3) begin failures++; $display("FAIL b2b_corr_hold got=%0d exp=3", bus.corr_count); end
   endtask

   task automatic test_reset_mid_search();
      int lat;
      int stale;
      @(negedge clk);
      bus.in_word  = 16'h1FFF;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (99) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.corr_count !== 16'd0) begin failures++; $display("FAIL rst_mid_corr got=%0d exp=0", bus.corr_count); end
      checks++; if (bus.fail_count !== 16'd0) begin failures++; $display("FAIL rst_mid_fail got=%0d exp=0", bus.fail_count); end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", bus.in_ready); end
      stale = 0;
      for (int c = 0; c < 720; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      checks++; if (stale !== 0) begin failures++; $display("FAIL rst_mid_stale got=%0d exp=0", stale); end
      send_and_wait(16'h0001, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL rst_mid_recover_latency got=%0d exp=2", lat); end
      take_result();
      checks++; if (bus.corr_count !== 16'd1) begin failures++; $display("FAIL rst_mid_recover_corr got=%0d exp=1", bus.corr_count); end
   endtask

   initial begin
      test_reset();
      test_zero_word();
      test_single_bit();
      test_last_triple();
      test_uncorrectable();
      test_back_to_back();
      test_reset_mid_search();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
